// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host controller: FSM encoding, frame size
// and the odd-parity helper used on both the receive and transmit paths.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RX       = 3'd1,
      ST_TX_RTS   = 3'd2,
      ST_TX_START = 3'd3,
      ST_TX_DATA  = 3'd4,
      ST_TX_ACK   = 3'd5,
      ST_TX_WAIT  = 3'd6
   } state_t;

   // start + 8 data + parity + stop
   localparam int FRAME_LEN = 11;

   // Bit that makes the total number of ones in {data, parity} odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_host_ctrl_if.sv
// Host-side bus of the PS/2 controller.
// Handshake: wr_ps2 is a single-cycle request that is taken only while
// tx_idle is high (ignored otherwise); rd_fifo pops the byte shown on dout
// and takes effect only while rx_empty is low. All *_tick outputs are
// single-cycle pulses. fsm_state mirrors the controller FSM for observation.
interface ps2_host_ctrl_if;
   import ps2_pkg::*;

   logic       wr_ps2;
   logic [7:0] din;
   logic       rd_fifo;
   logic       tx_idle;
   logic       tx_done_tick;
   logic       tx_err_tick;
   logic [7:0] dout;
   logic       rx_empty;
   logic       rx_full;
   logic       rx_err_tick;
   logic       rx_ovf_tick;
   state_t     fsm_state;

   modport master (
      output wr_ps2, din, rd_fifo,
      input  tx_idle, tx_done_tick, tx_err_tick, dout, rx_empty, rx_full,
             rx_err_tick, rx_ovf_tick, fsm_state
   );

   modport slave (
      input  wr_ps2, din, rd_fifo,
      output tx_idle, tx_done_tick, tx_err_tick, dout, rx_empty, rx_full,
             rx_err_tick, rx_ovf_tick, fsm_state
   );

endinterface

// File: rtl/ps2_fifo.sv
// Receive FIFO, first-word fall-through. Pointers carry one extra wrap bit
// so full and empty are told apart by the MSB. A write into a full FIFO is
// dropped (and flagged) unless a read frees the slot in the same cycle.
module ps2_fifo #(
   parameter int AW = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr,
   input  logic [7:0] din,
   input  logic       rd,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full,
   output logic       ovf_tick
);

   localparam int DEPTH = 2 ** AW;

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wp;
   logic [AW:0] rp;
   logic        do_rd;
   logic        do_wr;

   assign empty = (wp == rp);
   assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_rd = rd && !empty;
   assign do_wr = wr && (!full || do_rd);
   assign dout  = empty ? 8'h00 : mem[rp[AW-1:0]];

   // Storage write; the slot under rp is read combinationally before the edge.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wp[AW-1:0]] <= din;
      end
   end

   // Pointer advance and overflow pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp       <= '0;
         rp       <= '0;
         ovf_tick <= 1'b0;
      end else begin
         if (do_wr) begin
            wp <= wp + 1'b1;
         end
         if (do_rd) begin
            rp <= rp + 1'b1;
         end
         ovf_tick <= wr && !do_wr;
      end
   end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host controller: clock glitch filter, receive and transmit FSM with
// a frame watchdog, and a small receive FIFO. Both PS/2 lines are
// open-collector: this block only ever pulls them low or releases them.
module ps2_host_ctrl
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int INHIBIT_CYC = 5000,
   parameter int TIMEOUT_CYC = 100000,
   parameter int FIFO_AW     = 2
) (
   input  logic            clk,
   input  logic            reset,
   ps2_host_ctrl_if.slave  bus,
   inout  wire             ps2d,
   inout  wire             ps2c
);

   localparam int         INH_W    = $clog2(INHIBIT_CYC + 1);
   localparam int         WD_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 2);

   state_t                state;
   logic [FILTER_LEN-1:0] filt_reg;
   logic                  f_reg;
   logic                  f_next;
   logic                  fall;
   logic                  d_meta;
   logic                  d_sync;
   logic [3:0]            bit_cnt;
   logic [8:0]            rx_sr;
   logic [8:0]            tx_sr;
   logic [INH_W-1:0]      inh_cnt;
   logic [WD_W-1:0]       wd_cnt;
   logic                  wd_expired;
   logic                  c_drive;
   logic                  d_drive;
   logic                  tx_done_tick;
   logic                  tx_err_tick;
   logic                  rx_err_tick;
   logic [9:0]            rx_word;
   logic                  frame_ok;
   logic                  fifo_wr;

   assign ps2c = c_drive ? 1'b0 : 1'bz;
   assign ps2d = d_drive ? 1'b0 : 1'bz;

   // Clock filter and data synchroniser; the filter doubles as the ps2c synchroniser.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         filt_reg <= '1;
         f_reg    <= 1'b1;
         d_meta   <= 1'b1;
         d_sync   <= 1'b1;
      end else begin
         filt_reg <= {filt_reg[FILTER_LEN-2:0], ps2c};
         f_reg    <= f_next;
         d_meta   <= ps2d;
         d_sync   <= d_meta;
      end
   end

   // Filtered level changes only once every sample agrees.
   always_comb begin
      f_next = f_reg;
      if (&filt_reg) begin
         f_next = 1'b1;
      end else if (~|filt_reg) begin
         f_next = 1'b0;
      end
   end

   assign fall       = f_reg && !f_next;
   assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   // rx_sr holds {parity, data}; the stop bit arrives with the final fall.
   assign rx_word  = {d_sync, rx_sr};
   assign frame_ok = (^rx_word[8:0]) && rx_word[9];
   assign fifo_wr  = (state == ST_RX) && fall && (bit_cnt == LAST_BIT) && frame_ok;

   // Controller FSM: receive, request-to-send, transmit, acknowledge, watchdog.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         rx_sr        <= '0;
         tx_sr        <= '0;
         inh_cnt      <= '0;
         wd_cnt       <= '0;
         c_drive      <= 1'b0;
         d_drive      <= 1'b0;
         tx_done_tick <= 1'b0;
         tx_err_tick  <= 1'b0;
         rx_err_tick  <= 1'b0;
      end else begin
         tx_done_tick <= 1'b0;
         tx_err_tick  <= 1'b0;
         rx_err_tick  <= 1'b0;
         // Every state entry from an active state coincides with a fall,
         // so clearing on fall also covers the clear-on-entry rule.
         wd_cnt <= fall ? '0 : wd_cnt + 1'b1;
         case (state)
            ST_IDLE: begin
               wd_cnt  <= '0;
               c_drive <= 1'b0;
               d_drive <= 1'b0;
               if (bus.wr_ps2) begin
                  tx_sr   <= {odd_parity(bus.din), bus.din};
                  inh_cnt <= '0;
                  c_drive <= 1'b1;
                  state   <= ST_TX_RTS;
               end else if (fall && !d_sync) begin
                  bit_cnt <= '0;
                  state   <= ST_RX;
               end
            end
            ST_RX: begin
               if (fall) begin
                  rx_sr   <= {d_sync, rx_sr[8:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) begin
                     rx_err_tick <= !frame_ok;
                     state       <= ST_IDLE;
                  end
               end else if (wd_expired) begin
                  rx_err_tick <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_TX_RTS: begin
               wd_cnt <= '0;
               if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                  c_drive <= 1'b0;
                  d_drive <= 1'b1;
                  state   <= ST_TX_START;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            ST_TX_START: begin
               if (fall) begin
                  d_drive <= !tx_sr[0];
                  tx_sr   <= {1'b0, tx_sr[8:1]};
                  bit_cnt <= 4'd1;
                  state   <= ST_TX_DATA;
               end else if (wd_expired) begin
                  d_drive     <= 1'b0;
                  tx_err_tick <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_TX_DATA: begin
               if (fall) begin
                  if (bit_cnt == LAST_BIT) begin
                     d_drive <= 1'b0;
                     state   <= ST_TX_ACK;
                  end else begin
                     d_drive <= !tx_sr[0];
                     tx_sr   <= {1'b0, tx_sr[8:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else if (wd_expired) begin
                  d_drive     <= 1'b0;
                  tx_err_tick <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_TX_ACK: begin
               if (fall) begin
                  if (!d_sync) begin
                     state <= ST_TX_WAIT;
                  end else begin
                     tx_err_tick <= 1'b1;
                     state       <= ST_IDLE;
                  end
               end else if (wd_expired) begin
                  tx_err_tick <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            ST_TX_WAIT: begin
               if (f_reg && d_sync) begin
                  tx_done_tick <= 1'b1;
                  state        <= ST_IDLE;
               end else if (wd_expired) begin
                  tx_err_tick <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               c_drive <= 1'b0;
               d_drive <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   ps2_fifo #(
      .AW(FIFO_AW)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr       (fifo_wr),
      .din      (rx_word[7:0]),
      .rd       (bus.rd_fifo),
      .dout     (bus.dout),
      .empty    (bus.rx_empty),
      .full     (bus.rx_full),
      .ovf_tick (bus.rx_ovf_tick)
   );

   assign bus.tx_idle      = (state == ST_IDLE);
   assign bus.tx_done_tick = tx_done_tick;
   assign bus.tx_err_tick  = tx_err_tick;
   assign bus.rx_err_tick  = rx_err_tick;
   assign bus.fsm_state    = state;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl: a behavioural PS/2 device drives and
// samples the open-collector lines while one initial block walks through
// receive, error, transmit, overflow, watchdog and reset scenarios.
module tb_ps2_host_ctrl;
   import ps2_pkg::*;

   localparam int HALF = 20;

   logic clk;
   logic reset;
   logic dev_c_low;
   logic dev_d_low;
   wire  ps2c;
   wire  ps2d;

   int checks;
   int errors;
   int n_tx_done;
   int n_tx_err;
   int n_rx_err;
   int n_rx_ovf;

   ps2_host_ctrl_if bus ();

   ps2_host_ctrl #(
      .FILTER_LEN  (4),
      .INHIBIT_CYC (20),
      .TIMEOUT_CYC (2000),
      .FIFO_AW     (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .ps2d  (ps2d),
      .ps2c  (ps2c)
   );

   pullup (ps2c);
   pullup (ps2d);
   assign ps2c = dev_c_low ? 1'b0 : 1'bz;
   assign ps2d = dev_d_low ? 1'b0 : 1'bz;

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // tick counters
   initial begin
      n_tx_done = 0;
      n_tx_err  = 0;
      n_rx_err  = 0;
      n_rx_ovf  = 0;
   end
   always @(posedge clk) begin
      if (bus.tx_done_tick) n_tx_done++;
      if (bus.tx_err_tick)  n_tx_err++;
      if (bus.rx_err_tick)  n_rx_err++;
      if (bus.rx_ovf_tick)  n_rx_ovf++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Device-to-host frame, first nclk bits of {stop=1, par, data, start=0}.
   task automatic dev_send(input logic [7:0] data, input logic par, input int nclk);
      logic [10:0] bits;
      bits = {1'b1, par, data, 1'b0};
      for (int i = 0; i < nclk; i++) begin
         dev_d_low = ~bits[i];
         repeat (10) @(negedge clk);
         dev_c_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_c_low = 1'b0;
         repeat (10) @(negedge clk);
      end
      dev_d_low = 1'b0;
   endtask

   // Device clocks nclk host-to-device bits, sampling ps2d before each rise.
   task automatic dev_recv(input int nclk, output logic [9:0] got);
      got = '0;
      repeat (30) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         dev_c_low = 1'b1;
         repeat (HALF) @(negedge clk);
         got[i] = ps2d;
         dev_c_low = 1'b0;
         repeat (HALF) @(negedge clk);
      end
   endtask

   // Acknowledge clock: pull data low when ack is set.
   task automatic dev_ack(input logic ack);
      dev_d_low = ack;
      repeat (10) @(negedge clk);
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_d_low = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   // Host write request; measures how long ps2c is held low.
   task automatic host_tx(input logic [7:0] b, output int low_cyc, output logic start_low);
      low_cyc = 0;
      bus.din    = b;
      bus.wr_ps2 = 1'b1;
      @(negedge clk);
      bus.wr_ps2 = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         if (ps2c === 1'b0) low_cyc++;
         else if (low_cyc > 0) break;
         @(negedge clk);
      end
      start_low = (ps2d === 1'b0);
   endtask

   task automatic pop();
      bus.rd_fifo = 1'b1;
      @(negedge clk);
      bus.rd_fifo = 1'b0;
   endtask

   initial begin
      logic [9:0] got;
      logic       start_low;
      logic [7:0] rx_bytes [5];
      logic       rx_par   [5];
      int         low_cyc;
      int         b_done, b_err, b_rx, b_ovf;
      int         elapsed;

      checks = 0;
      errors = 0;
      rx_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      rx_par   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      reset       = 1'b1;
      dev_c_low   = 1'b0;
      dev_d_low   = 1'b0;
      bus.wr_ps2  = 1'b0;
      bus.din     = 8'h00;
      bus.rd_fifo = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_tx_idle", 32'(bus.tx_idle), 32'd1);
      check("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
      check("rst_rx_full", 32'(bus.rx_full), 32'd0);
      check("rst_dout", 32'(bus.dout), 32'h00);
      check("rst_state", 32'(bus.fsm_state), 32'(ST_IDLE));
      check("rst_ticks", 32'({bus.tx_done_tick, bus.tx_err_tick, bus.rx_err_tick, bus.rx_ovf_tick}), 32'd0);
      check("rst_lines", 32'({ps2c, ps2d}), 32'b11);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // good frame 0xAA, parity 1
      b_rx = n_rx_err;
      dev_send(8'hAA, 1'b1, 11);
      repeat (5) @(negedge clk);
      check("rx_aa_dout", 32'(bus.dout), 32'hAA);
      check("rx_aa_nonempty", 32'(bus.rx_empty), 32'd0);
      check("rx_aa_no_err", 32'(n_rx_err - b_rx), 32'd0);
      pop();
      check("rx_aa_popped", 32'(bus.rx_empty), 32'd1);

      // bad parity frame 0x55, parity 0
      b_rx = n_rx_err;
      dev_send(8'h55, 1'b0, 11);
      repeat (5) @(negedge clk);
      check("rx_par_err", 32'(n_rx_err - b_rx), 32'd1);
      check("rx_par_empty", 32'(bus.rx_empty), 32'd1);

      // host transmit 0xF4 with device ack
      b_done = n_tx_done;
      b_err  = n_tx_err;
      host_tx(8'hF4, low_cyc, start_low);
      check("tx_inhibit_len", 32'(low_cyc), 32'd20);
      check("tx_start_low", 32'(start_low), 32'd1);
      check("tx_state_start", 32'(bus.fsm_state), 32'(ST_TX_START));
      dev_recv(10, got);
      check("tx_f4_bits", 32'(got[8:0]), 32'h0F4);
      check("tx_f4_stop", 32'(got[9]), 32'd1);
      dev_ack(1'b1);
      check("tx_f4_done", 32'(n_tx_done - b_done), 32'd1);
      check("tx_f4_no_err", 32'(n_tx_err - b_err), 32'd0);
      check("tx_f4_idle", 32'(bus.tx_idle), 32'd1);

      // host transmit 0x00 without ack
      b_done = n_tx_done;
      b_err  = n_tx_err;
      host_tx(8'h00, low_cyc, start_low);
      dev_recv(10, got);
      check("tx_00_bits", 32'(got[8:0]), 32'h100);
      dev_ack(1'b0);
      check("tx_nak_err", 32'(n_tx_err - b_err), 32'd1);
      check("tx_nak_no_done", 32'(n_tx_done - b_done), 32'd0);
      check("tx_nak_idle", 32'(bus.tx_idle), 32'd1);

      // fill the FIFO and overflow it
      b_ovf = n_rx_ovf;
      b_rx  = n_rx_err;
      for (int i = 0; i < 4; i++) dev_send(rx_bytes[i], rx_par[i], 11);
      repeat (5) @(negedge clk);
      check("fifo_full", 32'(bus.rx_full), 32'd1);
      check("fifo_no_ovf_yet", 32'(n_rx_ovf - b_ovf), 32'd0);
      dev_send(rx_bytes[4], rx_par[4], 11);
      repeat (5) @(negedge clk);
      check("fifo_ovf", 32'(n_rx_ovf - b_ovf), 32'd1);
      check("fifo_no_rx_err", 32'(n_rx_err - b_rx), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("fifo_pop%0d", i), 32'(bus.dout), 32'(rx_bytes[i]));
         pop();
      end
      check("fifo_drained", 32'(bus.rx_empty), 32'd1);

      // device stops after start + 4 data bits: watchdog
      b_rx = n_rx_err;
      dev_send(8'h3C, 1'b0, 5);
      check("wd_state_rx", 32'(bus.fsm_state), 32'(ST_RX));
      elapsed = 30;
      while (!bus.rx_err_tick && elapsed < 3000) begin
         @(negedge clk);
         elapsed++;
      end
      check("wd_window", 32'(elapsed >= 2000 && elapsed <= 2012), 32'd1);
      repeat (3) @(negedge clk);
      check("wd_err_once", 32'(n_rx_err - b_rx), 32'd1);
      check("wd_idle", 32'(bus.fsm_state), 32'(ST_IDLE));
      check("wd_no_write", 32'(bus.rx_empty), 32'd1);

      // reset in the middle of TX_DATA
      b_done = n_tx_done;
      b_err  = n_tx_err;
      host_tx(8'h00, low_cyc, start_low);
      dev_recv(3, got);
      check("mid_state_data", 32'(bus.fsm_state), 32'(ST_TX_DATA));
      check("mid_d_driven", 32'(ps2d), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_lines", 32'({ps2c, ps2d}), 32'b11);
      check("mid_rst_idle", 32'(bus.tx_idle), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check("mid_rst_no_tick", 32'((n_tx_done - b_done) + (n_tx_err - b_err)), 32'd0);
      check("mid_rst_empty", 32'(bus.rx_empty), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
